pulse_width_capture: RTL and testbench
======================================

Name: pulse_width_capture

Overview:
- Sits directly downstream of the free-running gated counter, which counts while `en` is high and clears when it is low.
- Watches the same `en` gate and that counter's `counts` bus. On each falling edge of `en`, it latches the final count, which is the pulse width in clk cycles.
- Buffers captured widths in a small FIFO and presents them on a valid/ready stream to the consumer (e.g. a register-bank or DMA shim).
- Also flags counter wrap-around and counts measurements dropped on overflow.

Parameters:
- CW, 23, width of counts bus and of each captured width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- MIN_WIDTH, 1, pulses with captured width < MIN_WIDTH are discarded as glitches; 0 disables the filter.
- DROP_W, 8, width of the dropped-measurement counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- en  in  1  gate, same net that drives the counter's en.
- counts  in  CW  counter output.
- clr  in  1  synchronous clear of FIFO, drop_cnt and flags.
- m_data  out  CW  captured width at FIFO head.
- m_ovf  out  1  head entry's counter wrapped during the pulse.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts head when m_valid & m_ready.
- busy  out  1  pulse in progress (registered en).
- full  out  1  FIFO holds DEPTH entries.
- drop_cnt  out  DROP_W  measurements lost to full FIFO; saturates at all-ones.

Behaviour:
- Reset (rst low, async): en_d=0, prev_cnt=0, wrap flag=0, FIFO empty.
  - Outputs during reset: m_valid=0, full=0, busy=0, drop_cnt=0, m_data=0, m_ovf=0.
- Edge detect: en_d is en registered. fall = en_d & ~en. rise = ~en_d & en.
- States: IDLE (en_d=0) and ACTIVE (en_d=1).
  - IDLE -> ACTIVE on rise: clear wrap flag, prev_cnt<=0.
  - ACTIVE -> IDLE on fall: capture.
- Wrap detection in ACTIVE: when counts < prev_cnt, set wrap flag; prev_cnt<=counts every ACTIVE cycle.
  - Example with CW=23: 7FFFFF->0 sets the flag.
- Capture on fall: width = counts sampled that cycle. The counter has not yet cleared, so width equals the number of cycles en was high.
  - If width < MIN_WIDTH: discard; no FIFO write, no drop increment.
  - Else if FIFO not full, or a pop occurs in the same cycle: write {wrap flag, width}.
  - Else: drop, and drop_cnt+1 (saturating).
- Latency: the entry becomes visible (m_valid=1, m_data valid) one clk after the fall cycle.
- FIFO: DEPTH entries, log2(DEPTH)+1-bit pointers.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - When full, a push is accepted only with a simultaneous pop.
  - m_data/m_ovf show the head entry; they are stable while m_valid=1 and m_ready=0.
- clr: takes effect next edge. Empties FIFO, zeroes drop_cnt and wrap flag; en_d is retained.
  - clr has priority over a push or pop in the same cycle; that capture is lost and not counted as a drop.
- Pulse in progress at reset deassertion with en=1: the first edge sees rise and starts a measurement.
  - That measurement is partial because the counter may be nonzero. It is captured as-is; no special flag.
- Width 0 (en high for 0 cycles) cannot occur. A fall with counts=0 is treated as width 0 and is subject to the MIN_WIDTH filter.

Optional Feature:
- Macro `PWC_MINMAX_EN`.
- When defined, adds outputs `min_w` [CW] and `max_w` [CW], plus `mm_valid` [1].
  - Updated on every accepted (non-glitch) capture, including dropped ones.
  - Update rule: `min_w` <= min(min_w, width), `max_w` <= max(max_w, width).
  - The first capture after reset or clr loads both and sets `mm_valid`.
  - Reset/clr values: `min_w` = all-ones, `max_w` = 0, `mm_valid` = 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic capture: en high 10 cycles, m_ready=1 -> one beat m_data=10, m_ovf=0, m_valid one cycle after the fall.
- Backpressure/full: DEPTH=4, m_ready=0, 6 pulses of widths 3,4,5,6,7,8 -> full=1 after the 4th; drop_cnt=2; draining gives 3,4,5,6 in order.
- Simultaneous push/pop while full: hold full, assert m_ready in the fall cycle of a width-9 pulse -> pops head, enqueues 9, drop_cnt unchanged.
- Glitch filter: MIN_WIDTH=3, pulses of width 1, 2, 3 -> only 3 enqueued; drop_cnt=0.
- Wrap: CW=4, en high 20 cycles -> m_data=4, m_ovf=1. Next pulse of width 5 -> m_ovf=0.
- Reset/clr mid-operation: assert rst low mid-pulse with 2 entries queued -> m_valid=0 and drop_cnt=0 immediately (async). With `PWC_MINMAX_EN`, widths 7,2,9 -> min_w=2, max_w=9; clr -> min_w=all-ones, max_w=0, mm_valid=0.

Source files
------------

// File: rtl/pulse_width_capture.sv
// rtl/pulse_width_capture.sv - captures gated-counter pulse widths into a FIFO stream.
// Optional min/max width tracking is enabled by defining PWC_MINMAX_EN.
module pulse_width_capture #(
  parameter int CW        = 23,
  parameter int DEPTH     = 4,
  parameter int MIN_WIDTH = 1,
  parameter int DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CW-1:0]     counts,
  input  logic              clr,
  output logic [CW-1:0]     m_data,
  output logic              m_ovf,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              full,
`ifdef PWC_MINMAX_EN
  output logic [CW-1:0]     min_w,
  output logic [CW-1:0]     max_w,
  output logic              mm_valid,
`endif
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic              rise;
  logic              fall;
  logic [CW-1:0]     prev_cnt;
  logic              wrap;
  logic              wrap_now;
  logic              accept;
  logic              cap;
  logic              push;
  logic              pop;
  logic              drop;
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [CW:0]       mem [DEPTH];
  logic [CW:0]       head;

  // The state register is the registered copy of en (en_d).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    rise       = 1'b0;
    fall       = 1'b0;
    case (state)
      IDLE:    if (en)  begin state_next = ACTIVE; rise = 1'b1; end
      ACTIVE:  if (!en) begin state_next = IDLE;   fall = 1'b1; end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == ACTIVE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_cnt <= '0;
      wrap     <= 1'b0;
    end else begin
      if (rise) begin
        prev_cnt <= '0;
        wrap     <= 1'b0;
      end else if (busy) begin
        prev_cnt <= counts;
        if (counts < prev_cnt) wrap <= 1'b1;
      end
      if (clr) wrap <= 1'b0;
    end
  end

  // A wrap seen on the fall cycle itself still belongs to this pulse.
  assign wrap_now = wrap | (busy & (counts < prev_cnt));

  generate
    if (MIN_WIDTH == 0) begin : g_nofilt
      assign accept = 1'b1;
    end else begin : g_filt
      localparam logic [CW-1:0] MW = CW'(MIN_WIDTH);
      assign accept = (counts >= MW);
    end
  endgenerate

  assign cap  = fall & accept;
  assign pop  = m_valid & m_ready;
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  assign m_valid = (wptr != rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr[AW-1:0]] <= {wrap_now, counts};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Head is masked so an empty FIFO presents zeros instead of stale storage.
  assign head   = mem[rptr[AW-1:0]];
  assign m_data = m_valid ? head[CW-1:0] : '0;
  assign m_ovf  = m_valid & head[CW];

`ifdef PWC_MINMAX_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_w    <= '1;
      max_w    <= '0;
      mm_valid <= 1'b0;
    end else if (clr) begin
      min_w    <= '1;
      max_w    <= '0;
      mm_valid <= 1'b0;
    end else if (cap) begin
      mm_valid <= 1'b1;
      if (!mm_valid || (counts < min_w)) min_w <= counts;
      if (!mm_valid || (counts > max_w)) max_w <= counts;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_width_capture.sv
// tb/tb_pulse_width_capture.sv - directed and random pulse stimulus against a queue-based model.
module tb_pulse_width_capture;
  localparam int CW     = 4;
  localparam int DEPTH  = 4;
  localparam int MIN_W  = 3;
  localparam int DROP_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              clr = 1'b0;
  logic              m_ready = 1'b0;
  logic [CW-1:0]     counts = '0;
  logic [CW-1:0]     m_data;
  logic              m_ovf;
  logic              m_valid;
  logic              busy;
  logic              full;
  logic [DROP_W-1:0] drop_cnt;
`ifdef PWC_MINMAX_EN
  logic [CW-1:0]     min_w;
  logic [CW-1:0]     max_w;
  logic              mm_valid;
`endif

  pulse_width_capture #(.CW(CW), .DEPTH(DEPTH), .MIN_WIDTH(MIN_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .en(en), .counts(counts), .clr(clr),
    .m_data(m_data), .m_ovf(m_ovf), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .full(full),
`ifdef PWC_MINMAX_EN
    .min_w(min_w), .max_w(max_w), .mm_valid(mm_valid),
`endif
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Upstream gated counter feeding the capture block.
  always @(posedge clk) counts <= en ? counts + 1'b1 : '0;

  typedef struct {
    logic          ovf;
    logic [CW-1:0] w;
  } ent_t;

  ent_t q[$];
  int   drops_m = 0;
  int   mn_m = (1 << CW) - 1;
  int   mx_m = 0;
  bit   mmv_m = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    drops_m = 0;
    mn_m = (1 << CW) - 1;
    mx_m = 0;
    mmv_m = 0;
  endtask

  // One fall: optional pop first, then the capture competes for space.
  task automatic model_fall(input int w, input bit ovf, input bit popped);
    ent_t e;
    if (popped && q.size() > 0) void'(q.pop_front());
    if (w < MIN_W) return;
    if (!mmv_m || w < mn_m) mn_m = w;
    if (!mmv_m || w > mx_m) mx_m = w;
    mmv_m = 1;
    if (q.size() < DEPTH) begin
      e.ovf = ovf;
      e.w   = CW'(w);
      q.push_back(e);
    end else if (drops_m < (1 << DROP_W) - 1) begin
      drops_m++;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".m_valid"}, 32'(m_valid), 32'(q.size() > 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(drops_m));
    if (q.size() > 0) begin
      chk({tag, ".m_data"}, 32'(m_data), 32'(q[0].w));
      chk({tag, ".m_ovf"}, 32'(m_ovf), 32'(q[0].ovf));
    end else begin
      chk({tag, ".m_data_empty"}, 32'(m_data), 32'd0);
    end
`ifdef PWC_MINMAX_EN
    chk({tag, ".mm_valid"}, 32'(mm_valid), 32'(mmv_m));
    chk({tag, ".min_w"}, 32'(min_w), 32'(mn_m));
    chk({tag, ".max_w"}, 32'(max_w), 32'(mx_m));
`endif
  endtask

  // en high for n sampled cycles; the width is n modulo 2^CW, wrapped once n reaches 2^CW.
  task automatic pulse(input int n, input bit pop_at_fall, input bit clr_at_fall);
    bit had = (q.size() > 0);
    en = 1'b1;
    repeat (n) step();
    chk("pulse.busy", 32'(busy), 32'd1);
    chk("pulse.pre_fall_valid", 32'(m_valid), 32'(had));
    en = 1'b0;
    m_ready = pop_at_fall;
    clr = clr_at_fall;
    step();
    m_ready = 1'b0;
    clr = 1'b0;
    if (clr_at_fall) model_clear();
    else model_fall(n % (1 << CW), n >= (1 << CW), pop_at_fall);
    chk("pulse.busy_after", 32'(busy), 32'd0);
  endtask

  task automatic pop_one(input string tag);
    check_state(tag);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clear();
    check_state("clr");
  endtask

  int exp_w;

  initial begin
    // Reset state
    repeat (2) step();
    check_state("reset");
    chk("reset.busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step();

    // Basic capture, width 10
    pulse(10, 0, 0);
    check_state("basic");
    pop_one("basic.pop");
    check_state("basic.empty");

    // Backpressure: 3..8 with no consumer, two dropped
    for (int w = 3; w <= 8; w++) begin
      pulse(w, 0, 0);
      check_state("bp");
    end
    while (q.size() > 0) pop_one("bp.drain");

    // Full with simultaneous pop on the fall cycle
    for (int w = 3; w <= 6; w++) pulse(w, 0, 0);
    check_state("sim.full");
    pulse(9, 1, 0);
    check_state("sim.after");
    while (q.size() > 0) pop_one("sim.drain");

    // Glitch filter
    do_clr();
    pulse(1, 0, 0);
    pulse(2, 0, 0);
    pulse(3, 0, 0);
    check_state("glitch");
    while (q.size() > 0) pop_one("glitch.drain");

    // Counter wrap then clean pulse
    pulse(20, 0, 0);
    check_state("wrap");
    pulse(5, 0, 0);
    pop_one("wrap.pop");
    check_state("wrap.next");
    pop_one("wrap.pop2");

    // Min/max tracking and clr
    pulse(7, 0, 0);
    pulse(3, 0, 0);
    pulse(9, 0, 0);
    check_state("mm");
    do_clr();

    // clr coincident with a fall loses the capture
    pulse(4, 0, 0);
    pulse(6, 0, 0);
    pulse(5, 0, 1);
    check_state("clr_fall");

    // Drop counter saturation
    for (int i = 0; i < DEPTH + 9; i++) pulse(3 + (i % 5), 0, 0);
    check_state("sat");
    do_clr();

    // Async reset mid-pulse with entries queued, released while en is still high
    pulse(4, 0, 0);
    pulse(5, 0, 0);
    en = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    model_clear();
    check_state("rst_async");
    chk("rst_async.busy", 32'(busy), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    exp_w = int'(counts);
    en = 1'b0;
    step();
    model_fall(exp_w, 1'b0, 1'b0);
    check_state("partial");
    while (q.size() > 0) pop_one("partial.drain");

    // Randomized pulses and drains
    for (int i = 0; i < 40; i++) begin
      pulse($urandom_range(1, 40), ($urandom % 4) == 0, 1'b0);
      check_state("rnd");
      repeat ($urandom_range(0, q.size())) pop_one("rnd.pop");
    end
    while (q.size() > 0) pop_one("rnd.drain");
    check_state("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
